uart_rx_frame: RTL

Byte-level UART receiver that consumes the mid-bit sample ticks produced by the baud-rate tick generator. It detects a start bit on the serial line and holds the tick generator enabled for one frame. It shifts in data bits LSB first, checks the stop bit, and presents each received byte in a one-entry holding register with a valid/ready handshake. It sits between the board RX pin and the byte-consuming logic (command decoder / APB UART bridge).

---
 rtl/uart_rx_frame.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: mid-bit sampled UART byte receiver with a
// one-entry valid/ready holding register.
// Ports: clk, RSTn (async, active-low), RXD (serial in),
//   clk_uart (sample tick), bps_en (tick gen enable),
//   rx_data/rx_valid/rx_ready (byte handshake),
//   overrun (sticky), frame_err/parity_err (pulses).
// Option: define UART_RX_PARITY_EN to add an even-parity bit.
module uart_rx_frame #(
  parameter int DATA_BITS = 8
) (
  input  logic       clk,
  input  logic       RSTn,
  input  logic       RXD,
  input  logic       clk_uart,
  output logic       bps_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       overrun,
  output logic       frame_err,
  output logic       parity_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t               r_state;
  logic                 r_rxd_m;
  logic                 r_rxd_s;
  logic                 r_rxd_d;
  logic [DATA_BITS-1:0] r_shift;
  logic [2:0]           r_cnt;
  logic                 r_bps_en;
  logic [7:0]           r_rx_data;
  logic                 r_rx_valid;
  logic                 r_overrun;
  logic                 r_frame_err;

  logic w_start;
  logic w_accept;
  logic w_par_ok;

  assign w_start  = r_rxd_d & ~r_rxd_s;
  assign w_accept = r_rx_valid & rx_ready;

`ifdef UART_RX_PARITY_EN
  logic r_par;
  logic r_parity_err;
  // even parity: parity bit equals XOR of the data bits
  assign w_par_ok   = (r_par == ^r_shift);
  assign parity_err = r_parity_err;
`else
  assign w_par_ok   = 1'b1;
  assign parity_err = 1'b0;
`endif

  assign bps_en    = r_bps_en;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

  // synchronizer resets to the idle-high line level
  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_rxd_m <= 1'b1;
      r_rxd_s <= 1'b1;
      r_rxd_d <= 1'b1;
    end else begin
      r_rxd_m <= RXD;
      r_rxd_s <= r_rxd_m;
      r_rxd_d <= r_rxd_s;
    end
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_bps_en    <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par        <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      if (w_accept)
        r_rx_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state  <= S_START;
            r_bps_en <= 1'b1;
          end
        end
        S_START: begin
          if (clk_uart) begin
            if (!r_rxd_s) begin
              r_cnt   <= '0;
              r_state <= S_DATA;
            end else begin
              r_state  <= S_IDLE;
              r_bps_en <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (clk_uart) begin
            // LSB arrives first, so shift in at the top
            r_shift <= {r_rxd_s, r_shift[DATA_BITS-1:1]};
            r_cnt   <= r_cnt + 3'd1;
            if (r_cnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end
        end
        S_PARITY: begin
          if (clk_uart) begin
`ifdef UART_RX_PARITY_EN
            r_par <= r_rxd_s;
`endif
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (clk_uart) begin
            r_bps_en <= 1'b0;
            if (!r_rxd_s) begin
              r_frame_err <= 1'b1;
              r_state     <= S_BREAK;
            end else if (w_par_ok) begin
              r_rx_data  <= 8'(r_shift);
              r_rx_valid <= 1'b1;
              // a same-cycle accept frees the slot
              if (r_rx_valid && !rx_ready)
                r_overrun <= 1'b1;
              r_state <= S_IDLE;
            end else begin
`ifdef UART_RX_PARITY_EN
              r_parity_err <= 1'b1;
`endif
              r_state <= S_IDLE;
            end
          end
        end
        S_BREAK: begin
          if (r_rxd_s)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
